// File: rtl/mem_arbiter.sv
// Memory port arbiter: icache refill vs dcache refill/writeback, one txn at a time.
// Define MEM_ARB_RR_EN for round-robin grant; default is fixed dcache priority.
module mem_arbiter #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ic_req_valid,
  input  logic [ADDR_W-1:0]   ic_req_addr,
  output logic                ic_req_ready,
  output logic                ic_resp_valid,
  output logic [DATA_W-1:0]   ic_resp_data,
  input  logic                dc_req_valid,
  input  logic                dc_req_rw,
  input  logic [ADDR_W-1:0]   dc_req_addr,
  input  logic [DATA_W-1:0]   dc_req_wdata,
  input  logic [DATA_W/8-1:0] dc_req_wmask,
  output logic                dc_req_ready,
  output logic                dc_resp_valid,
  output logic [DATA_W-1:0]   dc_resp_data,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_req_rw,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic                mem_req_data_valid,
  input  logic                mem_req_data_ready,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_resp_data,
  output logic                busy
);

  localparam int MASK_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    WDATA,
    RESP
  } state_t;

  state_t              state;
  logic                own_dc;
  logic                rw_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [MASK_W-1:0]   wmask_q;
  logic                ic_grant;
  logic                dc_grant;
  logic                can_accept;
  logic                accept;

`ifdef MEM_ARB_RR_EN
  // 1 = dcache won the last grant, 0 = icache
  logic last_grant;
  assign dc_grant = dc_req_valid & (~ic_req_valid | ~last_grant);
`else
  assign dc_grant = dc_req_valid;
`endif
  assign ic_grant = ic_req_valid & ~dc_grant;

  assign can_accept   = (state == IDLE) & ~reset;
  assign ic_req_ready = can_accept & ic_grant;
  assign dc_req_ready = can_accept & dc_grant;
  assign accept       = ic_req_ready | dc_req_ready;

  assign busy               = (state != IDLE);
  assign mem_req_valid      = (state == CMD);
  assign mem_req_data_valid = (state == WDATA);
  assign mem_req_rw         = rw_q;
  assign mem_req_addr       = addr_q;
  assign mem_req_wdata      = wdata_q;
  assign mem_req_wmask      = wmask_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      own_dc        <= 1'b0;
      rw_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wmask_q       <= '0;
      ic_resp_valid <= 1'b0;
      ic_resp_data  <= '0;
      dc_resp_valid <= 1'b0;
      dc_resp_data  <= '0;
`ifdef MEM_ARB_RR_EN
      last_grant    <= 1'b0;
`endif
    end else begin
      ic_resp_valid <= 1'b0;
      dc_resp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            own_dc  <= dc_grant;
            rw_q    <= dc_grant & dc_req_rw;
            addr_q  <= dc_grant ? dc_req_addr : ic_req_addr;
            wdata_q <= dc_grant ? dc_req_wdata : '0;
            wmask_q <= dc_grant ? dc_req_wmask : '0;
`ifdef MEM_ARB_RR_EN
            last_grant <= dc_grant;
`endif
            state   <= CMD;
          end
        end
        CMD: begin
          if (mem_req_ready) begin
            state <= rw_q ? WDATA : RESP;
          end
        end
        WDATA: begin
          // only the dcache ever writes
          if (mem_req_data_ready) begin
            dc_resp_valid <= 1'b1;
            dc_resp_data  <= '0;
            state         <= IDLE;
          end
        end
        RESP: begin
          if (mem_resp_valid) begin
            if (own_dc) begin
              dc_resp_valid <= 1'b1;
              dc_resp_data  <= mem_resp_data;
            end else begin
              ic_resp_valid <= 1'b1;
              ic_resp_data  <= mem_resp_data;
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
